// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request and register-file write port bundle
// The arbiter takes the slave side; requesters and the register file see the master side.
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 3
);
   logic                 wb_hold;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*5-1:0]    req_rd;
   logic [NREQ*32-1:0]   req_data;
   logic                 wb_regwrite;
   logic [4:0]           wb_rd;
   logic [31:0]          writedata;
   logic [2:0]           wb_src;

   modport master (
      output wb_hold,
      output req_valid,
      output req_rd,
      output req_data,
      input  req_ready,
      input  wb_regwrite,
      input  wb_rd,
      input  writedata,
      input  wb_src
   );

   modport slave (
      input  wb_hold,
      input  req_valid,
      input  req_rd,
      input  req_data,
      output req_ready,
      output wb_regwrite,
      output wb_rd,
      output writedata,
      output wb_src
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter: req 0 priority with burst limit, round-robin for the rest
// Optional conflict statistics counter enabled by RF_WB_STATS_EN.
module regfile_wb_arbiter #(
   parameter int NREQ      = 3,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   regfile_wb_arbiter_if.slave bus
`ifdef RF_WB_STATS_EN
   ,
   output logic [CNT_W-1:0]   conflict_cnt
`endif
);

   localparam int             IW     = 3;
   localparam logic [3:0]     MAX_B  = 4'(MAX_BURST);
   localparam logic [IW-1:0]  LAST   = IW'(NREQ - 1);
   localparam logic [IW-1:0]  FIRST  = IW'(1);

   typedef enum logic [0:0] {
      S_PRIO = 1'b0,
      S_FAIR = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_burst_cnt;
   logic [3:0]      w_burst_nxt;
   logic [IW-1:0]   r_rr_ptr;
   logic [IW-1:0]   w_rr_nxt;

   logic            r_wb_regwrite;
   logic [4:0]      r_wb_rd;
   logic [31:0]     r_writedata;
   logic [2:0]      r_wb_src;

   logic            w_other_valid;
   logic            w_hi_found;
   logic [IW-1:0]   w_hi_idx;
   logic            w_lo_found;
   logic [IW-1:0]   w_lo_idx;
   logic            w_rr_found;
   logic [IW-1:0]   w_rr_idx;
   logic            w_grant_any;
   logic [IW-1:0]   w_grant_idx;
   logic [NREQ-1:0] w_ready;
   logic [4:0]      w_sel_rd;
   logic [31:0]     w_sel_data;

   assign w_other_valid = |bus.req_valid[NREQ-1:1];

   // Round-robin pick: lowest valid index at or above the pointer, else lowest valid overall (wrap).
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_found = 1'b0;
      w_lo_idx   = '0;
      for (int i = NREQ - 1; i >= 1; i--) begin
         if (bus.req_valid[i]) begin
            w_lo_found = 1'b1;
            w_lo_idx   = IW'(i);
            if (IW'(i) >= r_rr_ptr) begin
               w_hi_found = 1'b1;
               w_hi_idx   = IW'(i);
            end
         end
      end
      w_rr_found = w_hi_found | w_lo_found;
      w_rr_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      if (!bus.wb_hold && !reset) begin
         if (r_state == S_PRIO && bus.req_valid[0] &&
             (!w_other_valid || r_burst_cnt < MAX_B)) begin
            w_grant_any = 1'b1;
            w_grant_idx = '0;
         end else if (w_rr_found) begin
            w_grant_any = 1'b1;
            w_grant_idx = w_rr_idx;
         end else if (bus.req_valid[0]) begin
            w_grant_any = 1'b1;
            w_grant_idx = '0;
         end
      end
   end

   always_comb begin
      w_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_ready[i] = w_grant_any && (w_grant_idx == IW'(i));
      end
   end

   assign bus.req_ready = w_ready;

   always_comb begin
      w_sel_rd   = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant_idx == IW'(i)) begin
            w_sel_rd   = bus.req_rd[5*i +: 5];
            w_sel_data = bus.req_data[32*i +: 32];
         end
      end
   end

   // The burst count only matters while someone else is waiting; hold freezes everything.
   always_comb begin
      w_state_nxt = r_state;
      w_burst_nxt = r_burst_cnt;
      w_rr_nxt    = r_rr_ptr;
      if (!bus.wb_hold) begin
         if (!w_other_valid) begin
            w_burst_nxt = '0;
            w_state_nxt = S_PRIO;
         end else if (w_grant_any && w_grant_idx == '0) begin
            w_burst_nxt = (r_burst_cnt == MAX_B) ? MAX_B : r_burst_cnt + 4'd1;
            if (w_burst_nxt == MAX_B) begin
               w_state_nxt = S_FAIR;
            end
         end else if (w_grant_any) begin
            w_burst_nxt = '0;
            w_state_nxt = S_PRIO;
         end
         if (w_grant_any && w_grant_idx != '0) begin
            w_rr_nxt = (w_grant_idx == LAST) ? FIRST : w_grant_idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_PRIO;
         r_burst_cnt <= '0;
         r_rr_ptr    <= FIRST;
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_rr_ptr    <= w_rr_nxt;
      end
   end

   // An x0 destination still completes the handshake but never enables the write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wb_regwrite <= 1'b0;
         r_wb_rd       <= '0;
         r_writedata   <= '0;
         r_wb_src      <= '0;
      end else if (w_grant_any) begin
         r_wb_regwrite <= (w_sel_rd != 5'd0);
         r_wb_rd       <= w_sel_rd;
         r_writedata   <= w_sel_data;
         r_wb_src      <= w_grant_idx;
      end else begin
         r_wb_regwrite <= 1'b0;
      end
   end

   assign bus.wb_regwrite = r_wb_regwrite;
   assign bus.wb_rd       = r_wb_rd;
   assign bus.writedata   = r_writedata;
   assign bus.wb_src      = r_wb_src;

`ifdef RF_WB_STATS_EN
   logic [3:0]       w_nvalid;
   logic             w_conflict;
   logic [CNT_W-1:0] r_conflict_cnt;

   always_comb begin
      w_nvalid = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_nvalid = w_nvalid + {3'b000, bus.req_valid[i]};
      end
      w_conflict = (w_nvalid >= 4'd2);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && !(&r_conflict_cnt)) begin
         r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
   end

   assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed table, reset corner case and randomized model check of regfile_wb_arbiter
// Conflict counter checks are compiled in with RF_WB_STATS_EN.
module tb_regfile_wb_arbiter;

   localparam int MAXB = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;

   regfile_wb_arbiter_if #(.NREQ(3)) bus ();

`ifdef RF_WB_STATS_EN
   logic [15:0] conflict_cnt;
`endif

   regfile_wb_arbiter #(.NREQ(3), .MAX_BURST(MAXB), .CNT_W(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus)
`ifdef RF_WB_STATS_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clock = ~clock;

   logic [31:0] rf [32];
   always @(negedge clock) begin
      if (bus.wb_regwrite) rf[bus.wb_rd] <= bus.writedata;
   end

   typedef struct {
      logic        hold;
      logic [2:0]  valid;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [2:0]  exp_ready;
   } vec_t;

   vec_t tbl [20];

   int n_vec = 0;
   int n_err = 0;

   // reference state
   int          streak;
   int          rr;
   int          e_conf;
   logic        e_we;
   logic [4:0]  e_rd;
   logic [31:0] e_data;
   logic [2:0]  e_src;
   logic        pend [3];
   logic [4:0]  prd  [3];
   logic [31:0] pdat [3];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int model_grant(input logic [2:0] v, input logic h);
      logic others;
      if (h) return -1;
      others = (v[2:1] != 2'b00);
      if (v[0] && (!others || streak < MAXB)) return 0;
      for (int off = 0; off < 2; off++) begin
         int k = 1 + (rr - 1 + off) % 2;
         if (v[k]) return k;
      end
      if (v[0]) return 0;
      return -1;
   endfunction

   task automatic model_step(input logic [2:0] v, input logic h, input int g);
      if (!h) begin
         if (v[2:1] == 2'b00) streak = 0;
         else if (g == 0) streak = (streak < MAXB) ? streak + 1 : MAXB;
         else if (g > 0) streak = 0;
         if (g > 0) rr = (g == 2) ? 1 : g + 1;
      end
      if (!reset && ((v[0] + v[1] + v[2]) >= 2)) e_conf++;
   endtask

   function automatic logic [63:0] outs(input logic we, input logic [4:0] rd,
                                         input logic [31:0] d, input logic [2:0] s);
      return {23'd0, we, rd, d, s};
   endfunction

   function automatic logic [63:0] dut_outs();
      return outs(bus.wb_regwrite, bus.wb_rd, bus.writedata, bus.wb_src);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b0, 3'b010, 5'd5, 32'hDEADBEEF, 3'b010};
      tbl[1]  = '{1'b0, 3'b001, 5'd0, 32'h12345678, 3'b001};
      tbl[2]  = '{1'b0, 3'b000, 5'd0, 32'h00000000, 3'b000};
      tbl[3]  = '{1'b1, 3'b111, 5'd7, 32'h11111111, 3'b000};
      tbl[4]  = '{1'b1, 3'b111, 5'd7, 32'h11111111, 3'b000};
      tbl[5]  = '{1'b1, 3'b111, 5'd7, 32'h11111111, 3'b000};
      tbl[6]  = '{1'b0, 3'b111, 5'd7, 32'h11111111, 3'b001};
      for (int i = 7; i <= 15; i++) tbl[i] = '{1'b0, 3'b101, 5'd3, 32'hAAAA0000, 3'b001};
      tbl[10].exp_ready = 3'b100;
      tbl[15].exp_ready = 3'b100;
      for (int i = 16; i <= 19; i++)
         tbl[i] = '{1'b0, 3'b110, 5'd9, 32'hBBBB0001, (i % 2 == 0) ? 3'b010 : 3'b100};

      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; prd[i] = '0; pdat[i] = '0; end

      // reset state, with every requester asking
      bus.wb_hold   = 1'b0;
      bus.req_valid = 3'b111;
      bus.req_rd    = {3{5'd1}};
      bus.req_data  = {3{32'h55555555}};
      #1 reset = 1'b1;
      #1;
      chk("reset_ready", 64'(bus.req_ready), 64'd0);
      chk("reset_outs", dut_outs(), 64'd0);
      @(negedge clock);
      chk("reset_ready_edge", 64'(bus.req_ready), 64'd0);
      bus.req_valid = 3'b000;
      reset = 1'b0;
      streak = 0; rr = 1; e_conf = 0;
      e_we = 1'b0; e_rd = '0; e_data = '0; e_src = '0;

      // directed table
      for (int i = 0; i < 20; i++) begin
         if (i != 0) @(negedge clock);
         bus.wb_hold   = tbl[i].hold;
         bus.req_valid = tbl[i].valid;
         bus.req_rd    = {3{tbl[i].rd}};
         bus.req_data  = {3{tbl[i].data}};
         #1;
         chk($sformatf("tbl%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
         if (tbl[i].exp_ready != 3'b000) begin
            e_we   = (tbl[i].rd != 5'd0);
            e_rd   = tbl[i].rd;
            e_data = tbl[i].data;
            e_src  = tbl[i].exp_ready[2] ? 3'd2 : (tbl[i].exp_ready[1] ? 3'd1 : 3'd0);
         end else begin
            e_we = 1'b0;
         end
         if ((tbl[i].valid[0] + tbl[i].valid[1] + tbl[i].valid[2]) >= 2) e_conf++;
         @(posedge clock);
         #1;
         chk($sformatf("tbl%0d_outs", i), dut_outs(), outs(e_we, e_rd, e_data, e_src));
      end
      @(negedge clock);
      bus.req_valid = 3'b000;
      #1;
      chk("rf5", 64'(rf[5]), 64'h00000000DEADBEEF);
      chk("rf0_untouched", 64'(rf[0]), 64'd0);
      chk("rf3", 64'(rf[3]), 64'h00000000AAAA0000);
      chk("rf9", 64'(rf[9]), 64'h00000000BBBB0001);
`ifdef RF_WB_STATS_EN
      chk("conflict_tbl", 64'(conflict_cnt), 64'(e_conf));
`endif

      // reset lands after an accept: outputs clear at once and the write never commits
      @(negedge clock);
      bus.wb_hold   = 1'b0;
      bus.req_valid = 3'b010;
      bus.req_rd    = {3{5'd4}};
      bus.req_data  = {3{32'hCAFEF00D}};
      @(posedge clock);
      #1;
      chk("pre_reset_outs", dut_outs(), outs(1'b1, 5'd4, 32'hCAFEF00D, 3'd1));
      #1 reset = 1'b1;
      #1;
      chk("mid_reset_outs", dut_outs(), 64'd0);
      chk("mid_reset_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clock);
      #1;
      chk("rf4_lost", 64'(rf[4]), 64'd0);
      bus.req_valid = 3'b000;
      reset = 1'b0;
      streak = 0; rr = 1; e_conf = 0;
      e_we = 1'b0; e_rd = '0; e_data = '0; e_src = '0;

      // randomized traffic against the model; requesters hold their request until accepted
      for (int c = 0; c < 3000; c++) begin
         int   g;
         logic h;
         logic [2:0] v;
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 3) < ((i == 0) ? 3 : 1)) begin
               pend[i] = 1'b1;
               prd[i]  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               pdat[i] = $urandom;
            end
         end
         h = ($urandom_range(0, 9) == 0);
         v = {pend[2], pend[1], pend[0]};
         bus.wb_hold   = h;
         bus.req_valid = v;
         bus.req_rd    = {prd[2], prd[1], prd[0]};
         bus.req_data  = {pdat[2], pdat[1], pdat[0]};
         #1;
         g = model_grant(v, h);
         chk("rand_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
         if (g >= 0) begin
            e_we   = (prd[g] != 5'd0);
            e_rd   = prd[g];
            e_data = pdat[g];
            e_src  = 3'(g);
            pend[g] = 1'b0;
         end else begin
            e_we = 1'b0;
         end
         model_step(v, h, g);
         @(posedge clock);
         #1;
         chk("rand_outs", dut_outs(), outs(e_we, e_rd, e_data, e_src));
      end
`ifdef RF_WB_STATS_EN
      chk("conflict_rand", 64'(conflict_cnt), 64'(e_conf));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
